// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: per-latch enables and
// bubble strobes, a small wait/stall/halt FSM, and saturating stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             lw_hazard,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT   = 2'd2;
    localparam logic [1:0] HALTED     = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       mem_miss;
    logic       halt_now;
    logic       count_stall;
    logic       count_flush;

    assign mem_miss = dmem_req && !dhit;
    // A HALT reaching MEM still waits for its own data access to complete.
    assign halt_now = (state == HALTED) || (halt_mem && !mem_miss);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halt        = 1'b0;
        count_flush = 1'b0;
        next_state  = RUN;
        if (!nRST) begin
            next_state = RUN;
        end else if (halt_now) begin
            halt       = 1'b1;
            next_state = HALTED;
        end else if (mem_miss) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            next_state  = MEM_WAIT;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                count_flush = 1'b1;
            end else if (lw_hazard && state != LOAD_STALL) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                next_state = LOAD_STALL;
            end else if (jump_id) begin
                // The redirect cannot advance the PC until the fetch slot is valid.
                pc_en       = ihit;
                ifid_flush  = 1'b1;
                count_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    assign count_stall = nRST && !halt_now && !pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            if (count_stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (count_flush && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table, directed sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipeline_stall_ctrl;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic lw_hazard = 1'b0, ihit = 1'b0, dmem_req = 1'b0, dhit = 1'b0;
    logic branch_taken = 1'b0, jump_id = 1'b0, halt_mem = 1'b0;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .lw_hazard(lw_hazard), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .branch_taken(branch_taken),
        .jump_id(jump_id), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .lw_hazard(lw_hazard), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .branch_taken(branch_taken),
        .jump_id(jump_id), .halt_mem(halt_mem),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush),
        .halt(s_halt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 CLK = ~CLK;

    // Output vector order: pc, ifid, idex, exmem, memwb enables; four flushes; halt.
    logic [9:0] dut_out;
    logic [9:0] sat_out;
    assign dut_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
    assign sat_out = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                      s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt};

    localparam logic [9:0] O_ZERO   = 10'b0000000000;
    localparam logic [9:0] O_HALT   = 10'b0000000001;
    localparam logic [9:0] O_MISS   = 10'b0000100010;
    localparam logic [9:0] O_BRANCH = 10'b1111111000;
    localparam logic [9:0] O_LOAD   = 10'b0011101000;
    localparam logic [9:0] O_JUMP   = 10'b1111110000;
    localparam logic [9:0] O_IMISS  = 10'b0111110000;
    localparam logic [9:0] O_RUN    = 10'b1111100000;

    // Input vector order: lw_hazard, ihit, dmem_req, dhit, branch_taken, jump_id, halt_mem.
    localparam logic [6:0] IDLE = 7'b0100000;

    int errors = 0;
    int checks = 0;

    bit m_halted = 1'b0;
    bit m_bubble = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    typedef struct {
        string      name;
        logic [6:0] vec;
        logic [9:0] exp;
    } vector_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Reference model: which rule wins this cycle, and the resulting strobes.
    task automatic model_eval(input logic [6:0] v, output logic [9:0] o, output int rule);
        logic lw, ih, dr, dh, bt, jp, hm;
        {lw, ih, dr, dh, bt, jp, hm} = v;
        if (m_halted || (hm && (!dr || dh))) begin rule = 1; o = O_HALT; end
        else if (dr && !dh)                 begin rule = 2; o = O_MISS; end
        else if (bt)                        begin rule = 3; o = O_BRANCH; end
        else if (lw && !m_bubble)           begin rule = 4; o = O_LOAD; end
        else if (jp)                        begin rule = 5; o = ih ? O_JUMP : O_IMISS; end
        else if (!ih)                       begin rule = 6; o = O_IMISS; end
        else                                begin rule = 7; o = O_RUN; end
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_bubble = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic applyStimulus(input logic [6:0] v);
        logic [9:0] exp;
        int rule;
        @(negedge CLK);
        nRST = 1'b1;
        {lw_hazard, ihit, dmem_req, dhit, branch_taken, jump_id, halt_mem} = v;
        #1;
        model_eval(v, exp, rule);
        check("outputs", dut_out, exp);
        check("sat_outputs", sat_out, exp);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        check("sat_stall_cnt", s_stall_cnt, sat3(m_stall));
        check("sat_flush_cnt", s_flush_cnt, sat3(m_flush));
        if (rule != 1 && !exp[9]) m_stall++;
        if (rule == 3 || rule == 5) m_flush++;
        m_halted = (rule == 1);
        m_bubble = (rule == 4);
    endtask

    // Asserts reset (left low until the next stimulus) with arbitrary inputs.
    task automatic checkOutput_reset();
        @(negedge CLK);
        nRST = 1'b0;
        {lw_hazard, ihit, dmem_req, dhit, branch_taken, jump_id, halt_mem} = 7'($urandom);
        #1;
        check("reset_outputs", dut_out, O_ZERO);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        check("reset_halt", halt, 0);
        model_reset();
    endtask

    initial begin
        vector_t table_v[12];
        logic [6:0] v;

        table_v[0]  = '{"idle",          7'b0100000, O_RUN};
        table_v[1]  = '{"imiss",         7'b0000000, O_IMISS};
        table_v[2]  = '{"load_use",      7'b1100000, O_LOAD};
        table_v[3]  = '{"branch_lw",     7'b1100100, O_BRANCH};
        table_v[4]  = '{"jump_hit",      7'b0100010, O_JUMP};
        table_v[5]  = '{"jump_imiss",    7'b0000010, O_IMISS};
        table_v[6]  = '{"dmiss_branch",  7'b0110100, O_MISS};
        table_v[7]  = '{"dhit",          7'b0111000, O_RUN};
        table_v[8]  = '{"halt_nomem",    7'b0100001, O_HALT};
        table_v[9]  = '{"halt_dmiss",    7'b0110001, O_MISS};
        table_v[10] = '{"halt_dhit",     7'b0111001, O_HALT};
        table_v[11] = '{"lw_jump",       7'b1100010, O_LOAD};

        // Reset behaviour, then release into normal running.
        checkOutput_reset();
        applyStimulus(IDLE);
        check("release_out", dut_out, O_RUN);
        applyStimulus(IDLE);
        check("release_stall", stall_cnt, 0);

        // Single-cycle decode from RUN, never clocked.
        for (int i = 0; i < 12; i++) begin
            checkOutput_reset();
            @(negedge CLK);
            nRST = 1'b1;
            {lw_hazard, ihit, dmem_req, dhit, branch_taken, jump_id, halt_mem} = table_v[i].vec;
            #1;
            check(table_v[i].name, dut_out, table_v[i].exp);
            nRST = 1'b0;
        end

        // Load-use: exactly one bubble even with the hazard held.
        checkOutput_reset();
        applyStimulus(7'b1100000);
        check("lu_c1_pc_en", pc_en, 0);
        check("lu_c1_ifid_en", ifid_en, 0);
        check("lu_c1_idex_flush", idex_flush, 1);
        applyStimulus(7'b1100000);
        check("lu_c2_out", dut_out, O_RUN);
        applyStimulus(IDLE);
        check("lu_stall_cnt", stall_cnt, 1);

        // Data-cache miss for three cycles, then the hit.
        checkOutput_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(7'b0110000);
            check("dmiss_out", dut_out, O_MISS);
        end
        applyStimulus(7'b0111000);
        check("dmiss_done_out", dut_out, O_RUN);
        applyStimulus(IDLE);
        check("dmiss_stall_cnt", stall_cnt, 3);

        // Branch beats load-use.
        checkOutput_reset();
        applyStimulus(7'b1100100);
        check("br_lw_out", dut_out, O_BRANCH);
        applyStimulus(IDLE);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 0);

        // Halt is sticky until reset.
        checkOutput_reset();
        applyStimulus(7'b0100001);
        check("halt_c1_out", dut_out, O_HALT);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(7'($urandom));
            check("halt_sticky", halt, 1);
            check("halt_pc_en", pc_en, 0);
        end
        checkOutput_reset();
        applyStimulus(IDLE);
        check("halt_cleared", halt, 0);

        // Saturation of the narrow counter.
        checkOutput_reset();
        for (int i = 0; i < 5; i++) applyStimulus(7'b0000000);
        applyStimulus(IDLE);
        check("sat_stall_hold", s_stall_cnt, 3);
        check("wide_stall_cnt", stall_cnt, 5);

        // Randomized traffic with occasional resets and rare halts.
        checkOutput_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                checkOutput_reset();
            end else begin
                v = 7'($urandom);
                v[0] = ($urandom_range(0, 63) == 0);
                applyStimulus(v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage pipeline. Consumes the hazard unit's load-use indication, cache hit signals, and branch/jump/halt events. Drives per-latch enable and flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable. Holds a small FSM for multi-cycle data-cache waits, single-bubble load-use stalls and halt, and keeps saturating performance counters.

## Interface
- CNT_W, 16, width of stall/flush performance counters
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- lw_hazard  in  1  load-use hazard from hazard unit (ID instr needs EX load result)
- ihit  in  1  instruction cache hit this cycle
- dmem_req  in  1  MEM stage instr is load/store
- dhit  in  1  data cache hit this cycle
- branch_taken  in  1  EX stage branch resolved taken
- jump_id  in  1  ID stage instr is J/JAL/JR
- halt_mem  in  1  HALT instr in MEM stage
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch write enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble into latch (only effective when that latch's enable=1)
- halt  out  1  sticky processor halt
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
- flush_cnt  out  CNT_W  cycles with ifid_flush=1 due to control flow, saturating

## Operation
- FSM states: RUN, LOAD_STALL, MEM_WAIT, HALTED. Reset state RUN.
- Outputs are combinational from state and inputs; state/counters/halt registered.
- Priority per cycle, highest first:
  1. HALTED, or halt_mem with (!dmem_req or dhit): all enables 0, all flushes 0, halt=1. Next state HALTED; leaves only by reset.
  2. MEM miss (dmem_req && !dhit): pc/ifid/idex/exmem_en=0; memwb_en=1, memwb_flush=1. Next MEM_WAIT. Stays while miss persists; on dhit, evaluate the lower priorities the same cycle, and next state is per rules 3-6.
  3. branch_taken: all enables 1; ifid_flush=1, idex_flush=1. lw_hazard and jump_id ignored. Next RUN.
  4. lw_hazard while state≠LOAD_STALL: pc_en=0, ifid_en=0; idex_en=1, idex_flush=1; exmem/memwb_en=1. Next LOAD_STALL.
  5. jump_id: all enables 1, ifid_flush=1. Next RUN.
  6. !ihit: pc_en=0; ifid_en=1, ifid_flush=1; others enabled. Next RUN.
  7. Otherwise all enables 1, no flushes. Next RUN.
- LOAD_STALL inserts at most one bubble: lw_hazard is ignored while in LOAD_STALL. Leave to RUN unless rule 1-2 fires.
- Multiple lower-priority events in one cycle are not merged: only the highest applies. Exception: rule 5 or 6 with !ihit also applies pc_en=0 (jump redirect waits for fetch).
- stall_cnt increments on every non-HALTED cycle with pc_en=0. flush_cnt increments on cycles where rule 3 or 5 fires. Both saturate at 2^CNT_W-1.

## Timing
- nRST low (any time, async): state=RUN, halt=0, counters=0. All enables and flushes forced 0 while nRST is low.
- First cycle after release: normal evaluation from RUN.
- Zero-latency control: enables/flushes valid the same cycle as the inputs. State changes on next CLK edge.
- Reset mid-MEM_WAIT or mid-HALTED: returns to RUN immediately. No residual stall.
- Counter increment visible one cycle after the qualifying cycle.

## Test plan
- Reset: hold nRST=0 with arbitrary inputs -> all outputs 0. Release with ihit=1, others 0 -> all enables 1, no flushes, stall_cnt stays 0.
- Load-use: lw_hazard=1 for 2 cycles -> cycle 1: pc_en=0, ifid_en=0, idex_flush=1. Cycle 2: all enables 1, no flush. stall_cnt=1.
- D-miss: dmem_req=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles pc/ifid/idex/exmem_en=0, memwb_flush=1. 4th cycle all enables 1. stall_cnt=3.
- Branch vs load-use: branch_taken=1, lw_hazard=1 same cycle -> pc_en=1, ifid_flush=1, idex_flush=1. No stall. flush_cnt=1.
- Halt: halt_mem=1, dmem_req=0 -> halt=1, all enables 0 from that cycle. Stays for 10 cycles with random inputs. nRST pulse clears halt=0.
- Saturation with CNT_W=2: 5 consecutive !ihit cycles -> stall_cnt reaches 3 and holds.
